// File: rtl/frm_cap_pkg.sv
// frm_cap_pkg: shared types and constants for the frame capture controller.
// State encoding, zoom modes and frame length width.
package frm_cap_pkg;

  localparam int LEN_W = 19;

  localparam int B_IDLE = 0;
  localparam int B_WAIT = 1;
  localparam int B_CAP  = 2;
  localparam int B_DONE = 3;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_WAIT = 4'b0010;
  localparam logic [3:0] ST_CAP  = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  localparam logic [1:0] ZOOM_2X      = 2'b00;
  localparam logic [1:0] ZOOM_4X      = 2'b01;
  localparam logic [1:0] ZOOM_8X      = 2'b10;
  localparam logic [1:0] ZOOM_INVALID = 2'b11;

  typedef struct packed {
    logic       zoom_en;
    logic       luma_cor;
    logic [1:0] zoom_mode;
  } cfg_t;

  function automatic logic mode_ok(input logic [1:0] m);
    return m != ZOOM_INVALID;
  endfunction

endpackage

// File: rtl/frm_cap_if.sv
// frm_cap_if: camera beat stream in, trim stage handshake out.
// slave is the controller view, master is the camera/trim side.
interface frm_cap_if;
  import frm_cap_pkg::*;

  logic             cam_sof_i;
  logic             cam_eof_i;
  logic             cam_vld_i;
  logic             cam_rdy_o;
  logic             trim_vld_o;
  logic             trim_rdy_i;
  logic [LEN_W-1:0] trim_len_i;

  modport master (
    output cam_sof_i, cam_eof_i, cam_vld_i,
    output trim_rdy_i, trim_len_i,
    input  cam_rdy_o, trim_vld_o
  );

  modport slave (
    input  cam_sof_i, cam_eof_i, cam_vld_i,
    input  trim_rdy_i, trim_len_i,
    output cam_rdy_o, trim_vld_o
  );

endinterface

// File: rtl/frm_cap_wdog.sv
// frm_cap_wdog: idle-beat watchdog for the capture state.
// expired fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
module frm_cap_wdog #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expired
);

  logic [23:0] cnt;

  assign expired = en & ~kick &
    (cnt == TIMEOUT_CYCLES - 24'd1);

  // count idle cycles, restart on any accepted beat
  always_ff @(posedge clk) begin
    if (rst || !en || kick) cnt <= '0;
    else                    cnt <= cnt + 24'd1;
  end

endmodule

// File: rtl/frm_cap_ctrl.sv
// frm_cap_ctrl: capture FSM gating camera beats into the trim stage.
// Watchdog abort is built only when FRM_CAP_TIMEOUT_EN is defined.
module frm_cap_ctrl
  import frm_cap_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_start_i,
  input  logic             cmd_stop_i,
  input  logic             cmd_cont_i,
  input  logic             cfg_zoom_en_i,
  input  logic             cfg_luma_cor_i,
  input  logic [1:0]       cfg_zoom_mode_i,
  frm_cap_if.slave         cam,
  output logic             en_zoom_o,
  output logic             en_luma_cor_o,
  output logic [1:0]       sel_zoom_mode_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic [15:0]      frm_cnt_o,
  output logic [LEN_W-1:0] last_len_o
);

  logic [3:0]       state;
  cfg_t             cfg_q;
  cfg_t             cfg_in;
  logic             cont_q;
  logic             stop_pend;
  logic             err_q;
  logic [15:0]      cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             sof_hit;
  logic             fwd;
  logic             acc;
  logic             eof_acc;
  logic             req;
  logic             start_ok;
  logic             start_bad;
  logic             wd_exp;

  assign cfg_in = {cfg_zoom_en_i, cfg_luma_cor_i,
                   cfg_zoom_mode_i};

  assign sof_hit = state[B_WAIT] & cam.cam_vld_i &
                   cam.cam_sof_i & ~cmd_stop_i;
  assign fwd = ~rst & (state[B_CAP] | sof_hit);

  assign cam.trim_vld_o = fwd & cam.cam_vld_i;
  assign cam.cam_rdy_o  = fwd ? cam.trim_rdy_i : 1'b1;

  assign acc     = cam.cam_vld_i & cam.cam_rdy_o;
  assign eof_acc = state[B_CAP] & acc & cam.cam_eof_i;

  assign req       = state[B_IDLE] & cmd_start_i &
                     ~cmd_stop_i;
  assign start_ok  = req & mode_ok(cfg_zoom_mode_i);
  assign start_bad = req & ~mode_ok(cfg_zoom_mode_i);

  assign busy_o          = ~rst & ~state[B_IDLE];
  assign done_o          = ~rst & state[B_DONE];
  assign err_o           = err_q;
  assign frm_cnt_o       = cnt_q;
  assign last_len_o      = len_q;
  assign en_zoom_o       = cfg_q.zoom_en;
  assign en_luma_cor_o   = cfg_q.luma_cor;
  assign sel_zoom_mode_o = cfg_q.zoom_mode;

`ifdef FRM_CAP_TIMEOUT_EN
  logic to_q;

  frm_cap_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state[B_CAP]),
    .kick    (acc),
    .expired (wd_exp)
  );

  // sticky abort flag, cleared by the next accepted start
  always_ff @(posedge clk) begin
    if (rst)           to_q <= 1'b0;
    else if (start_ok) to_q <= 1'b0;
    else if (wd_exp)   to_q <= 1'b1;
  end

  assign timeout_o = to_q;
`else
  assign wd_exp    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // capture FSM with status and config registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_q     <= '0;
      cont_q    <= 1'b0;
      stop_pend <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (1'b1)
        state[B_IDLE]: begin
          if (start_ok) begin
            state  <= ST_WAIT;
            cfg_q  <= cfg_in;
            cont_q <= cmd_cont_i;
            cnt_q  <= '0;
            len_q  <= '0;
          end else if (start_bad) begin
            err_q <= 1'b1;
          end
        end
        state[B_WAIT]: begin
          if (cmd_stop_i)   state <= ST_IDLE;
          else if (sof_hit) state <= ST_CAP;
        end
        state[B_CAP]: begin
          if (wd_exp) begin
            state     <= ST_IDLE;
            err_q     <= 1'b1;
            stop_pend <= 1'b0;
          end else begin
            if (cmd_stop_i) stop_pend <= 1'b1;
            if (eof_acc) begin
              if (cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
              len_q <= cam.trim_len_i;
              if (!cont_q || stop_pend || cmd_stop_i)
                state <= ST_DONE;
              else if (mode_ok(cfg_zoom_mode_i))
                cfg_q <= cfg_in;
              else
                err_q <= 1'b1;
            end
          end
        end
        state[B_DONE]: begin
          state     <= ST_IDLE;
          stop_pend <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frm_cap_ctrl.md
FRM_CAP_CTRL -- requirements
Module: frm_cap_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24'd2_000_000, the maximum number of idle cycles allowed between accepted beats while capturing.
REQ-002 The block SHALL use a single clock. Reset is synchronous and active-high.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cmd_start_i  in  1  one-cycle capture start pulse.
REQ-006 cmd_stop_i  in  1  one-cycle stop request pulse.
REQ-007 cmd_cont_i  in  1  capture mode, sampled at start: 0 = single frame, 1 = continuous.
REQ-008 cfg_zoom_en_i, cfg_luma_cor_i, cfg_zoom_mode_i[1:0]  in  1/1/2  requested zoom configuration.
REQ-009 cam_sof_i, cam_eof_i, cam_vld_i  in  1 each  camera beat framing and valid.
REQ-010 cam_rdy_o  out  1  ready back to the camera.
REQ-011 trim_vld_o  out  1  gated valid to the frame-trim stage.
REQ-012 trim_rdy_i  in  1  trim-stage ready.
REQ-013 trim_len_i  in  19  trim-stage frame byte length.
REQ-014 en_zoom_o, en_luma_cor_o, sel_zoom_mode_o[1:0]  out  1/1/2  registered configuration driven to the trim stage.
REQ-015 busy_o  out  1  high in any state other than IDLE.
REQ-016 done_o  out  1  one-cycle pulse when a capture completes.
REQ-017 err_o  out  1  one-cycle pulse when a request is rejected or a capture aborts.
REQ-018 timeout_o  out  1  sticky abort flag.
REQ-019 frm_cnt_o  out  16  frames captured since the last start.
REQ-020 last_len_o  out  19  length of the last captured frame.

Function
REQ-021 The FSM SHALL have the states IDLE, WAIT_SOF, CAPTURE and DONE.
REQ-022 In IDLE and WAIT_SOF: cam_rdy_o=1 and trim_vld_o=0, so all beats are dropped.
REQ-023 In CAPTURE: trim_vld_o=cam_vld_i and cam_rdy_o=trim_rdy_i.
REQ-024 A beat is accepted when cam_vld_i & cam_rdy_o.
REQ-025 IDLE->WAIT_SOF occurs on cmd_start_i & !cmd_stop_i & cfg_zoom_mode_i!=2'b11. On that transition the block latches the config, latches cmd_cont_i, clears frm_cnt_o, clears last_len_o and clears timeout_o.
REQ-026 cmd_start_i with cfg_zoom_mode_i==2'b11 SHALL pulse err_o and keep the FSM in IDLE.
REQ-027 cmd_start_i asserted together with cmd_stop_i in IDLE SHALL be ignored.
REQ-028 cmd_start_i outside IDLE SHALL be ignored.
REQ-029 WAIT_SOF->CAPTURE occurs on a cycle with cam_vld_i & cam_sof_i. That sof beat is forwarded combinationally in the same cycle: trim_vld_o=1 and cam_rdy_o=trim_rdy_i.
REQ-030 cmd_stop_i in WAIT_SOF SHALL go to IDLE next cycle without pulsing done_o.
REQ-031 The config outputs SHALL change only in IDLE, in WAIT_SOF, or in the cycle after an accepted eof beat. They are never updated mid-frame.
REQ-032 Accepted eof beat in CAPTURE: frm_cnt_o increments and saturates at 16'hFFFF; last_len_o<=trim_len_i.
REQ-033 Eof handling in single mode, or in continuous mode with stop_pending=1: the FSM goes to DONE.
REQ-034 Eof handling in continuous mode with stop_pending=0: the FSM stays in CAPTURE and the latched config reloads from the cfg_* inputs, unless cfg_zoom_mode_i==2'b11. In that case the old config is kept and err_o pulses.
REQ-035 cmd_stop_i in CAPTURE SHALL set stop_pending; the current frame always completes.
REQ-036 cmd_stop_i coincident with an accepted eof beat SHALL end the capture at that eof.
REQ-037 DONE SHALL last one cycle with done_o=1, then go to IDLE and clear stop_pending.
REQ-038 frm_cnt_o and last_len_o SHALL hold their values in IDLE until the next accepted start.
REQ-039 Latency: the trim handshake path is combinational with zero cycles. Status outputs update one cycle after the triggering beat.

Reset
REQ-040 rst SHALL put the FSM in IDLE and clear stop_pending.
REQ-041 rst SHALL force busy_o, done_o, err_o, timeout_o and trim_vld_o to 0, and cam_rdy_o to 1.
REQ-042 rst SHALL clear frm_cnt_o, last_len_o, en_zoom_o, en_luma_cor_o and sel_zoom_mode_o to 0.
REQ-043 rst asserted mid-frame SHALL abort the capture immediately, with no done_o pulse. Remaining beats of that frame are dropped.

Configuration
REQ-044 With FRM_CAP_TIMEOUT_EN defined, a 24-bit watchdog runs in CAPTURE: it clears on every accepted beat and increments otherwise.
REQ-045 When the watchdog reaches TIMEOUT_CYCLES, the FSM goes to IDLE, err_o pulses and timeout_o sets. timeout_o clears on the next accepted start.
REQ-046 Without FRM_CAP_TIMEOUT_EN, no watchdog logic is built and timeout_o is tied to 0.

Structure
REQ-047 Shared package frm_cap_pkg SHALL hold the state encoding (one-hot, 4 bits), the zoom mode constants ZOOM_2X=2'b00, ZOOM_4X=2'b01, ZOOM_8X=2'b10 and ZOOM_INVALID=2'b11, and the frame length width (19).
REQ-048 The watchdog SHALL be a sub-module, frm_cap_wdog, instantiated only under FRM_CAP_TIMEOUT_EN.

Verification
REQ-049 Single capture: start with cont=0 and zoom_mode=01, then a 3-frame stream with trim_len_i=0x4B00. Expected: frame 1 dropped before its sof, frame 2 forwarded, done_o on the cycle after its eof, frm_cnt_o=1, last_len_o=0x4B00, frame 3 dropped.
REQ-050 Continuous capture with stop: start with cont=1, stop pulsed mid frame 3. Expected: frame 3 completes, done_o pulses, frm_cnt_o=3.
REQ-051 Invalid mode: start with zoom_mode=11. Expected: err_o pulses once, busy_o stays 0, config outputs unchanged.
REQ-052 Backpressure: trim_rdy_i toggling 1/0 during a frame. Expected: cam_rdy_o mirrors trim_rdy_i, no beat is lost, and a mid-frame cfg change does not alter sel_zoom_mode_o until after eof.
REQ-053 Reset mid-frame at beat 100. Expected: busy_o=0, frm_cnt_o=0, cam_rdy_o=1 on the next cycle, and no done_o pulse.
REQ-054 With FRM_CAP_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall cam_vld_i for 16 cycles in CAPTURE. Expected: err_o pulses, timeout_o=1, FSM in IDLE.
